// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with mid-bit sampling, stop-bit check and exported FSM code
//   clk        system clock
//   rst_n      asynchronous active-low reset (released synchronously inside)
//   baud_tick  one-cycle strobe at OVERSAMPLE x baud rate
//   rx         raw serial line, idle high, asynchronous to clk
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle pulse: rx_data updated
//   frame_err  one-cycle pulse: stop bit sampled low
//   busy       high whenever state != IDLE
//   state      FSM code (00 IDLE, 01 START, 10 DATA, 11 STOP), used as a downstream mux select
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [1:0]           state
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    // START compares the pre-increment count one early so the start check lands
    // OVERSAMPLE/2-1 ticks after detection and every later sample a full bit after it
    localparam logic [CW-1:0] START_LAST = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] IDX_LAST   = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t               cur, nxt;
    logic [1:0]           rst_pipe;
    logic                 rst_sync_n;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        idx, idx_nxt;
    logic [DATA_BITS-1:0] sh, sh_nxt, data_nxt;
    logic                 armed, armed_nxt, valid_nxt, err_nxt;

    // reset asserts immediately but releases on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_sync_n = rst_pipe[1];

    assign rx_s  = sync[1];
    assign state = cur;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sync      <= 2'b11;
            cur       <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            armed     <= 1'b1;
        end else begin
            sync      <= {sync[0], rx};
            cur       <= nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            sh        <= sh_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= err_nxt;
            busy      <= nxt != IDLE;
            armed     <= armed_nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sh_nxt    = sh;
        data_nxt  = rx_data;
        armed_nxt = armed;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (baud_tick) begin
            case (cur)
                IDLE: begin
                    // after a framing error the line must be seen high before a new start counts
                    if (rx_s) armed_nxt = 1'b1;
                    else if (armed) begin
                        nxt     = START;
                        cnt_nxt = '0;
                    end
                end
                START: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == START_LAST) begin
                        cnt_nxt = '0;
                        idx_nxt = '0;
                        nxt     = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == BIT_LAST) begin
                        cnt_nxt = '0;
                        sh_nxt  = {rx_s, sh[DATA_BITS-1:1]};
                        idx_nxt = idx + BW'(1);
                        nxt     = idx == IDX_LAST ? STOP : DATA;
                    end
                end
                STOP: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == BIT_LAST) begin
                        cnt_nxt   = '0;
                        nxt       = IDLE;
                        data_nxt  = rx_s ? sh : rx_data;
                        valid_nxt = rx_s;
                        err_nxt   = !rx_s;
                        armed_nxt = rx_s;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized frames checked against a tick-level timing model
module tb_uart_rx_core;
    logic       clk = 1'b0;
    logic       rst_n, baud_tick, rx;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;
    logic [1:0] state;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int         vectors = 0, miscompares = 0;
    int         t = 0;
    logic       line[$];
    int         valid_ticks[$];
    int         err_count = 0, busy_count = 0;
    bit         m_in, m_armed;
    int         m_t0;
    logic [7:0] m_bits, m_data;
    logic [1:0] exp_state;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // model: frame timing from the start-detect tick t0; start checked at t0+7,
    // bit i at t0+7+16*(i+1), stop at t0+151
    task automatic model_tick(input logic v, output logic ev, output logic ee);
        int r;
        ev = 1'b0;
        ee = 1'b0;
        if (!m_in) begin
            if (v) m_armed = 1'b1;
            else if (m_armed) begin
                m_in = 1'b1;
                m_t0 = t;
            end
        end else begin
            r = t - m_t0;
            if (r == 7) begin
                if (v) m_in = 1'b0;
            end else if (r < 151 && r > 7 && (r - 7) % 16 == 0) begin
                m_bits[(r - 7) / 16 - 1] = v;
            end else if (r == 151) begin
                m_in = 1'b0;
                if (v) begin
                    m_data = m_bits;
                    ev = 1'b1;
                end else begin
                    ee = 1'b1;
                    m_armed = 1'b0;
                end
            end
        end
        r = t - m_t0;
        exp_state = !m_in ? 2'b00 : r < 7 ? 2'b01 : r < 135 ? 2'b10 : 2'b11;
    endtask

    // one baud tick every 4 clocks; rx settles 3 clocks ahead of the tick
    task automatic step(input logic v);
        logic ev, ee;
        rx = v;
        baud_tick = 1'b0;
        @(negedge clk);
        chk("hold_state", 32'(state), 32'(exp_state));
        chk("pulse_idle", 32'({rx_valid, frame_err}), 32'(0));
        repeat (2) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        model_tick(v, ev, ee);
        chk("state", 32'(state), 32'(exp_state));
        chk("busy", 32'(busy), 32'(exp_state != 2'b00));
        chk("rx_valid", 32'(rx_valid), 32'(ev));
        chk("frame_err", 32'(frame_err), 32'(ee));
        chk("rx_data", 32'(rx_data), 32'(m_data));
        if (rx_valid) valid_ticks.push_back(t);
        err_count += int'(frame_err);
        busy_count += int'(busy);
        t++;
    endtask

    function automatic void push_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 160; i++)
            line.push_back(i < 16 ? 1'b0 : i < 144 ? b[(i - 16) / 16] : stop);
    endfunction

    function automatic void push_level(input logic v, input int n);
        for (int i = 0; i < n; i++) line.push_back(v);
    endfunction

    task automatic play(input int n);
        for (int i = 0; i < n && line.size() > 0; i++) step(line.pop_front());
    endtask

    task automatic play_all();
        while (line.size() > 0) step(line.pop_front());
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_valid"}, 32'(rx_valid), 32'(0));
        chk({tag, "_err"}, 32'(frame_err), 32'(0));
        chk({tag, "_data"}, 32'(rx_data), 32'(0));
    endtask

    task automatic model_reset();
        line.delete();
        m_in = 1'b0;
        m_armed = 1'b1;
        m_data = 8'h00;
        m_bits = 8'h00;
        exp_state = 2'b00;
    endtask

    initial begin
        int         t1;
        logic [7:0] b;
        logic       sb;
        rst_n = 1'b0;
        rx = 1'b1;
        baud_tick = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single frame 0xA5
        valid_ticks.delete();
        err_count = 0;
        push_level(1'b1, 4);
        t1 = t + 4;
        push_frame(8'hA5, 1'b1);
        push_level(1'b1, 4);
        play_all();
        chk("t1_data", 32'(rx_data), 32'h A5);
        chk("t1_pulses", 32'(valid_ticks.size()), 32'(1));
        chk("t1_latency", 32'(valid_ticks.size() > 0 ? valid_ticks[0] - t1 : -1), 32'(151));
        chk("t1_err", 32'(err_count), 32'(0));

        // 2: back-to-back 0x00 then 0xFF
        valid_ticks.delete();
        push_frame(8'h00, 1'b1);
        push_frame(8'hFF, 1'b1);
        push_level(1'b1, 5);
        play_all();
        chk("t2_pulses", 32'(valid_ticks.size()), 32'(2));
        chk("t2_spacing", 32'(valid_ticks.size() > 1 ? valid_ticks[1] - valid_ticks[0] : -1), 32'(160));
        chk("t2_data", 32'(rx_data), 32'h FF);

        // 3: 4-tick low glitch
        valid_ticks.delete();
        err_count = 0;
        busy_count = 0;
        push_level(1'b1, 3);
        push_level(1'b0, 4);
        push_level(1'b1, 10);
        play_all();
        chk("t3_busy_ticks", 32'(busy_count), 32'(7));
        chk("t3_pulses", 32'(valid_ticks.size() + err_count), 32'(0));

        // 4: framing error, long break, then a clean frame
        valid_ticks.delete();
        err_count = 0;
        push_frame(8'h3C, 1'b0);
        push_level(1'b0, 640);
        push_level(1'b1, 4);
        play_all();
        chk("t4_err_pulses", 32'(err_count), 32'(1));
        chk("t4_no_valid", 32'(valid_ticks.size()), 32'(0));
        chk("t4_data_kept", 32'(rx_data), 32'h FF);
        push_frame(8'h81, 1'b1);
        push_level(1'b1, 4);
        play_all();
        chk("t4_data", 32'(rx_data), 32'h 81);
        chk("t4_valid", 32'(valid_ticks.size()), 32'(1));

        // 5: async reset during data bit 4
        push_frame(8'h5A, 1'b1);
        play(88);
        chk("t5_pre_state", 32'(state), 32'(2));
        #2 rst_n = 1'b0;
        rx = 1'b1;
        #1;
        chk_reset_outputs("t5_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        valid_ticks.delete();
        push_level(1'b1, 4);
        push_frame(8'h12, 1'b1);
        push_level(1'b1, 4);
        play_all();
        chk("t5_data", 32'(rx_data), 32'h 12);
        chk("t5_valid", 32'(valid_ticks.size()), 32'(1));

        // 6: baud_tick stalled mid-frame while rx wanders
        push_level(1'b1, 2);
        push_frame(8'hC3, 1'b1);
        push_level(1'b1, 3);
        play(71);
        chk("t6_pre_state", 32'(state), 32'(2));
        repeat (1000) begin
            rx = 1'($urandom);
            @(negedge clk);
        end
        chk("t6_hold_state", 32'(state), 32'(2));
        chk("t6_hold_busy", 32'(busy), 32'(1));
        play_all();
        chk("t6_data", 32'(rx_data), 32'h C3);

        // randomized frames, occasionally with a bad stop bit
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            sb = $urandom_range(0, 3) != 0;
            push_frame(b, sb);
            push_level(1'b1, int'($urandom_range(1, 12)));
            play_all();
            if (sb) chk("rand_data", 32'(rx_data), 32'(b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Oversampling UART receiver front end. It synchronises the serial rx line, detects the start bit, samples each data bit at mid-bit, checks the stop bit, and delivers a parallel byte with a one-cycle valid strobe.
It also exports its 2-bit FSM state code. The downstream 4:1 rx output mux uses that code as its select to route per-state status and data onto the rx datapath.

Parameters:
DATA_BITS, 8, number of data bits per frame (LSB first), range 5..9
OVERSAMPLE, 16, baud_tick strobes per bit period; must be even and >= 4

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
baud_tick  input  1  single-cycle strobe at OVERSAMPLE x baud rate
rx  input  1  raw serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  last correctly framed byte
rx_valid  output  1  one-cycle pulse: rx_data updated
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high whenever state != IDLE
state  output  2  FSM code: 00 IDLE, 01 START, 10 DATA, 11 STOP; drives downstream mux sel

Behaviour:
- Reset (async assert, sync deassert by clk): sync FFs = 1, state = IDLE, tick counter = 0, bit index = 0, shift reg = 0, rx_data = 0, rx_valid = 0, frame_err = 0, busy = 0, armed = 1.
- Reset mid-frame aborts immediately. The partial byte is discarded and no valid or error pulse is produced.
- rx passes through a 2-FF synchroniser; all decisions use rx_s, the second FF output.
- Counters and the FSM advance only on cycles with baud_tick = 1. With baud_tick = 0, all state holds and rx_valid/frame_err return to 0.
- IDLE: on a tick, if rx_s = 1 then set armed = 1. If armed = 1 and rx_s = 0, go to START with counter = 0.
- START: each tick increments the counter. On the tick where counter = OVERSAMPLE/2 - 1:
  - rx_s = 0: go to DATA, counter = 0, bit index = 0.
  - rx_s = 1: false start; go to IDLE with no pulse.
- DATA: each tick increments the counter. On the tick where counter = OVERSAMPLE - 1:
  - shift rx_s in at the MSB side, so the first bit received ends at LSB after DATA_BITS shifts;
  - counter = 0, bit index + 1;
  - after the DATA_BITS-th sample, go to STOP.
- STOP: same 16-tick timing. On the sampling tick:
  - rx_s = 1: load shift reg into rx_data, pulse rx_valid.
  - rx_s = 0: pulse frame_err, leave rx_data unchanged, clear armed.
  - In both cases return to IDLE.
- Clearing armed means a held-low line (break) cannot retrigger until rx_s is seen high on a tick.
- rx_valid and frame_err are registered and assert on the clk edge after the stop sampling tick, for exactly one cycle. They are never both high.
- Timing from the start-detect tick T0: data bit i is sampled at T0 + OVERSAMPLE/2 - 1 + OVERSAMPLE*(i+1). Stop is sampled at T0 + OVERSAMPLE/2 - 1 + OVERSAMPLE*(DATA_BITS+1), which is T0 + 151 ticks at the defaults.
- state and busy are registered, change only on tick edges, and are glitch-free for use as mux select.
- rx edges between ticks are ignored; there is no majority vote.
- Back-to-back frames: a start bit immediately after the stop sample is accepted on the next tick in IDLE, since armed = 1 and rx_s = 0.

Test Plan:
1. Defaults, baud_tick every 4 clks, send 0xA5 with valid stop -> rx_data = 0xA5, a single rx_valid pulse 151 ticks after start detect, state sequence 00 -> 01 -> 10 -> 11 -> 00, frame_err = 0.
2. Two back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses exactly 160 ticks apart, rx_data = 0x00 then 0xFF.
3. Low glitch of 4 ticks on an idle line -> return to IDLE from START at tick 7, no pulses, busy high for 7 ticks only.
4. Frame 0x3C with stop bit low, then line held low for 40 bit times, then high, then valid frame 0x81:
   - frame_err pulses once and rx_data stays at its previous value;
   - no restart occurs while the line is low;
   - 0x81 is then received correctly.
5. rst_n asserted during DATA bit 4 of frame 0x5A -> all outputs 0 and state 00 immediately (async); after release, a new frame 0x12 is received cleanly.
6. baud_tick held low for 1000 clks mid-frame -> no state change; resuming ticks completes the frame with the correct byte.
